table_rx_parser: RTL
====================

Name: table_rx_parser

Overview:
- Receive-side counterpart of the table printer. Consumes ASCII bytes from the UART RX and parses lines of `R*C*V` entries separated by spaces.
- Each parsed entry is written into a 25-cell, 2-bit-per-cell table (5x5).
- At end of line, the table is committed atomically to the `info_table` output that feeds the game and print logic.
- Malformed lines are rejected whole, and the published table is left untouched.

Parameters:
- ROWS, 5, number of rows; row digits are '1'..ROWS.
- COLS, 5, number of columns; column digits are '1'..COLS.
- VAL_MAX, 3, largest legal cell value digit ('0'..VAL_MAX).
- TIMEOUT_CYC, 5_000_000, idle cycles mid-line before abort. Used only with the timeout feature.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- uart_rx_valid  in  1  one-cycle pulse; `uart_rx_data` is valid in that cycle.
- uart_rx_data  in  8  received byte.
- clear  in  1  synchronous pulse: zero `info_table` and abort the line in progress.
- info_table  out  2*ROWS*COLS  committed table; cell k occupies bits [2k+1:2k], k=(row-1)*COLS+(col-1).
- entry_cnt  out  5  entries parsed in the last committed line; saturates at 31.
- done  out  1  one-cycle pulse on commit.
- err  out  1  one-cycle pulse when a line is rejected.
- err_code  out  2  latched cause of the last error: 1=range, 2=syntax, 3=timeout.
- busy  out  1  high while a line is in progress (any state other than S_IDLE).
- current_state  out  4  state encoding, for debug LEDs.

Behaviour:
- Reset: `info_table`, `entry_cnt`, `done`, `err`, `err_code`, `busy` are 0; state is S_IDLE; the shadow table is 0.
- Bytes are consumed only in cycles where `uart_rx_valid`=1; no backpressure. Each byte is processed in its arrival cycle.
- States: S_IDLE, S_ROW, S_STAR1, S_COL, S_STAR2, S_VAL, S_SEP, S_FLUSH.
- S_IDLE:
  - Space, CR and LF are ignored, so CR LF and empty lines produce no `done`.
  - A digit byte loads shadow <= `info_table` (merge semantics), clears the line entry counter, and is processed as a row digit: range check, then go to S_STAR1.
- S_ROW:
  - Space is skipped.
  - A digit 1..ROWS is latched -> S_STAR1.
- S_STAR1: '*' -> S_COL.
- S_COL: digit 1..COLS is latched -> S_STAR2.
- S_STAR2: '*' -> S_VAL.
- S_VAL: digit 0..VAL_MAX -> write shadow cell, increment entry counter (saturating), go to S_SEP.
- S_SEP:
  - Space -> S_ROW.
  - CR or LF -> commit: `info_table` <= shadow, `entry_cnt` <= counter, `done`=1 for one cycle the next cycle, go to S_IDLE.
- Range error: a digit outside its legal range -> `err_code`=1.
- Syntax error: any other unexpected byte in S_ROW..S_SEP (including CR/LF before the value) -> `err_code`=2.
- On any error: `err` pulses, state -> S_FLUSH. S_FLUSH discards bytes until CR/LF, then returns to S_IDLE. `info_table` is unchanged.
- Duplicate cells within one line: last write wins.
- `clear` has priority over everything, including a commit in the same cycle:
  - `info_table` and shadow <= 0, `entry_cnt` <= 0.
  - State -> S_IDLE. No `done`, no `err`.
- `done` and `err` are never high in the same cycle.
- Commit latency: `done` and the new `info_table` appear 1 cycle after the terminating byte's valid cycle.
- Reset mid-line: everything returns to reset values immediately (asynchronous).

Optional Feature:
- Macro: TABLE_RX_TIMEOUT_EN.
- With the macro defined:
  - A counter runs while state is neither S_IDLE nor S_FLUSH, and resets on every `uart_rx_valid`.
  - Reaching TIMEOUT_CYC -> `err` pulse, `err_code`=3, state -> S_IDLE directly (no flush). `info_table` is unchanged.
- Without the macro: no counter exists, a line waits indefinitely, and `err_code`=3 never occurs.

Decomposition:
- Package `table_pkg`:
  - ASCII constants (0x30, 0x2A, 0x20, 0x0D, 0x0A).
  - ROWS/COLS defaults.
  - CELL_W=2.
  - State encoding.
  - Error-code constants.
  - The cell-index function.
- The package is shared with the table printer.
- One natural sub-module, `ascii_digit_check`: combinational; takes byte and max, outputs is_digit, in_range, value[3:0]. It is instantiated three times (row, col, val).
- The FSM and the shadow/commit logic stay in the top module.

Test Plan:
- Send "1*1*3 5*5*2\r" from reset -> `done` pulse; `info_table`[1:0]=3, [49:48]=2, all other bits 0; `entry_cnt`=2.
- Next send "3*2*1\n" -> merge: cell 11 ([23:22])=1, cells 0 and 24 retained; `entry_cnt`=1.
- Send "6*1*1\r" -> `err` pulse, `err_code`=1; `info_table` unchanged; next line "2*2*2\r" commits normally.
- Send "1*1x\r\n" -> `err`, `err_code`=2; flush to CR; the LF is ignored in idle; no `done`.
- Assert `clear` in the same cycle as the terminating CR of "1*1*1\r" -> `info_table`=0, no `done`, state S_IDLE.
- With TABLE_RX_TIMEOUT_EN and TIMEOUT_CYC=100: send "1*1", then 100 idle cycles -> `err`, `err_code`=3, `busy`=0; without the macro -> no `err`, `busy` stays 1.

Source files
------------

// File: rtl/table_pkg.sv
// Shared definitions for the table receive parser and the table printer:
// ASCII codes, table geometry defaults, parser state encoding, error codes
// and the row/column to cell-index mapping.
package table_pkg;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_STAR = 8'h2A;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    localparam int ROWS_DEF = 5;
    localparam int COLS_DEF = 5;
    localparam int CELL_W   = 2;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ROW   = 4'd1,
        S_STAR1 = 4'd2,
        S_COL   = 4'd3,
        S_STAR2 = 4'd4,
        S_VAL   = 4'd5,
        S_SEP   = 4'd6,
        S_FLUSH = 4'd7
    } state_t;

    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_SYNTAX  = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Rows and columns are 1-based as typed by the user; cells are 0-based.
    function automatic int cell_index(input int row, input int col, input int cols);
        return (row - 1) * cols + (col - 1);
    endfunction

endpackage

// File: rtl/ascii_digit_check.sv
// Classifies one received byte as an ASCII decimal digit and checks it
// against an upper bound. Purely combinational.
module ascii_digit_check
    import table_pkg::*;
(
    input  logic [7:0] i_byte,
    input  logic [3:0] i_max,
    output logic       o_is_digit,
    output logic       o_in_range,
    output logic [3:0] o_value
);

    // Decode digit, its binary value, and the upper-bound check
    always_comb begin
        o_is_digit = (i_byte >= ASCII_0) && (i_byte <= (ASCII_0 + 8'd9));
        o_value    = o_is_digit ? 4'(i_byte - ASCII_0) : 4'd0;
        o_in_range = o_is_digit && (o_value <= i_max);
    end

endmodule

// File: rtl/table_rx_parser.sv
// Parses lines of "R*C*V" entries from the UART receiver into a shadow table
// and commits the shadow to info_table atomically at end of line. Bad lines
// are dropped whole. Optional mid-line idle timeout: TABLE_RX_TIMEOUT_EN.
//
//   state   | meaning
//   S_IDLE  | between lines; whitespace ignored, a digit starts a line
//   S_ROW   | expecting a row digit (spaces skipped)
//   S_STAR1 | expecting '*' after the row
//   S_COL   | expecting a column digit
//   S_STAR2 | expecting '*' after the column
//   S_VAL   | expecting a value digit
//   S_SEP   | entry complete; space for next entry, CR/LF commits
//   S_FLUSH | line rejected; discard bytes until CR/LF
module table_rx_parser
    import table_pkg::*;
#(
    parameter int ROWS        = ROWS_DEF,
    parameter int COLS        = COLS_DEF,
    parameter int VAL_MAX     = 3,
    parameter int TIMEOUT_CYC = 5_000_000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        uart_rx_valid,
    input  logic [7:0]                  uart_rx_data,
    input  logic                        clear,
    output logic [CELL_W*ROWS*COLS-1:0] info_table,
    output logic [4:0]                  entry_cnt,
    output logic                        done,
    output logic                        err,
    output logic [1:0]                  err_code,
    output logic                        busy,
    output logic [3:0]                  current_state
);

    localparam int TBL_W = CELL_W * ROWS * COLS;
    localparam int IW    = $clog2(TBL_W);

    state_t           r_state, w_state_nxt;
    logic [TBL_W-1:0] r_table, r_shadow;
    logic [3:0]       r_row, r_col;
    logic [4:0]       r_line_cnt, r_entry_cnt;
    logic             r_done, r_err;
    logic [1:0]       r_err_code;

    logic       w_row_dig, w_row_rng, w_col_dig, w_col_rng, w_val_dig, w_val_rng;
    logic [3:0] w_row_val, w_col_val, w_val_val;
    logic       w_row_ok, w_col_ok, w_is_sp, w_is_eol, w_is_star;
    logic       w_load, w_latch_row, w_latch_col, w_write, w_commit;
    logic       w_err_range, w_err_syntax, w_timeout;
    logic [IW-1:0] w_bit;

    ascii_digit_check u_row_chk (
        .i_byte(uart_rx_data), .i_max(4'(ROWS)),
        .o_is_digit(w_row_dig), .o_in_range(w_row_rng), .o_value(w_row_val)
    );
    ascii_digit_check u_col_chk (
        .i_byte(uart_rx_data), .i_max(4'(COLS)),
        .o_is_digit(w_col_dig), .o_in_range(w_col_rng), .o_value(w_col_val)
    );
    ascii_digit_check u_val_chk (
        .i_byte(uart_rx_data), .i_max(4'(VAL_MAX)),
        .o_is_digit(w_val_dig), .o_in_range(w_val_rng), .o_value(w_val_val)
    );

    // Row and column digits are 1-based, so zero is out of range for them
    assign w_row_ok  = w_row_rng && (w_row_val != 4'd0);
    assign w_col_ok  = w_col_rng && (w_col_val != 4'd0);
    assign w_is_sp   = (uart_rx_data == ASCII_SP);
    assign w_is_star = (uart_rx_data == ASCII_STAR);
    assign w_is_eol  = (uart_rx_data == ASCII_CR) || (uart_rx_data == ASCII_LF);
    assign w_bit     = IW'(cell_index(int'(r_row), int'(r_col), COLS) * CELL_W);

`ifdef TABLE_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] r_timer;
    logic          w_active;

    assign w_active  = (r_state != S_IDLE) && (r_state != S_FLUSH);
    assign w_timeout = w_active && !uart_rx_valid && (r_timer == TW'(1));

    // Idle down-counter, reloaded on every byte and whenever no line is open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_timer <= TW'(TIMEOUT_CYC);
        else if (!w_active || uart_rx_valid || clear)
            r_timer <= TW'(TIMEOUT_CYC);
        else if (r_timer != '0)
            r_timer <= r_timer - 1'b1;
    end
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-byte datapath strobes
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_latch_row  = 1'b0;
        w_latch_col  = 1'b0;
        w_write      = 1'b0;
        w_commit     = 1'b0;
        w_err_range  = 1'b0;
        w_err_syntax = 1'b0;
        if (uart_rx_valid) begin
            case (r_state)
                S_IDLE: if (w_row_dig) begin
                    w_load = 1'b1;
                    if (w_row_ok) begin w_latch_row = 1'b1; w_state_nxt = S_STAR1; end
                    else          w_err_range = 1'b1;
                end
                S_ROW: if (!w_is_sp) begin
                    if (w_row_ok)       begin w_latch_row = 1'b1; w_state_nxt = S_STAR1; end
                    else if (w_row_dig) w_err_range  = 1'b1;
                    else                w_err_syntax = 1'b1;
                end
                S_STAR1: if (w_is_star) w_state_nxt = S_COL; else w_err_syntax = 1'b1;
                S_COL: begin
                    if (w_col_ok)       begin w_latch_col = 1'b1; w_state_nxt = S_STAR2; end
                    else if (w_col_dig) w_err_range  = 1'b1;
                    else                w_err_syntax = 1'b1;
                end
                S_STAR2: if (w_is_star) w_state_nxt = S_VAL; else w_err_syntax = 1'b1;
                S_VAL: begin
                    if (w_val_rng)      begin w_write = 1'b1; w_state_nxt = S_SEP; end
                    else if (w_val_dig) w_err_range  = 1'b1;
                    else                w_err_syntax = 1'b1;
                end
                S_SEP: begin
                    if (w_is_sp)       w_state_nxt = S_ROW;
                    else if (w_is_eol) begin w_commit = 1'b1; w_state_nxt = S_IDLE; end
                    else               w_err_syntax = 1'b1;
                end
                S_FLUSH: if (w_is_eol) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
        if (w_err_range || w_err_syntax) w_state_nxt = S_FLUSH;
        if (w_timeout)                   w_state_nxt = S_IDLE;
        if (clear)                       w_state_nxt = S_IDLE;
    end

    // Outputs decoded from state
    always_comb begin
        busy          = (r_state != S_IDLE);
        current_state = r_state;
    end

    // Shadow table, line counter and atomic commit; clear overrides a commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_table     <= '0;
            r_shadow    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_line_cnt  <= '0;
            r_entry_cnt <= '0;
        end else if (clear) begin
            r_table     <= '0;
            r_shadow    <= '0;
            r_line_cnt  <= '0;
            r_entry_cnt <= '0;
        end else begin
            if (w_load) begin
                r_shadow   <= r_table;
                r_line_cnt <= '0;
            end
            if (w_latch_row) r_row <= w_row_val;
            if (w_latch_col) r_col <= w_col_val;
            if (w_write) begin
                r_shadow[w_bit +: CELL_W] <= CELL_W'(w_val_val);
                if (r_line_cnt != 5'd31) r_line_cnt <= r_line_cnt + 5'd1;
            end
            if (w_commit) begin
                r_table     <= r_shadow;
                r_entry_cnt <= r_line_cnt;
            end
        end
    end

    // One-cycle done/err pulses and the latched error cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
        end else if (clear) begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_done <= w_commit;
            r_err  <= w_err_range || w_err_syntax || w_timeout;
            if (w_err_range)       r_err_code <= ERR_RANGE;
            else if (w_err_syntax) r_err_code <= ERR_SYNTAX;
            else if (w_timeout)    r_err_code <= ERR_TIMEOUT;
        end
    end

    assign info_table = r_table;
    assign entry_cnt  = r_entry_cnt;
    assign done       = r_done;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
